event_rr_arbiter: RTL and testbench
===================================

# event_rr_arbiter

Round-robin arbiter that merges `NUM_IN` handler event streams into a single event stream feeding one downstream handler. For example, several `NET_RECV` packet-processing replicas share one `OoO_DETECT` instance. The block holds one registered output slot and tags each event with its source index. It is fair, lossless and order-preserving per source, with one cycle of latency and full throughput.

## Interface
- `NUM_IN`, default 2: number of requesting event streams; legal range 2..8.
- `DATA_W`, default 96: event width in bits.
- `SRC_W`, default 1: width of the source tag; must equal max(1, clog2(`NUM_IN`)).

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_tdata`  in  `NUM_IN*DATA_W`: request data; requester i occupies bits [i*DATA_W +: DATA_W].
- `in_tvalid`  in  `NUM_IN`: per-requester valid.
- `in_tready`  out  `NUM_IN`: per-requester ready; at most one bit is high in any cycle.
- `out_tdata`  out  `DATA_W`: arbitrated event, registered.
- `out_tsrc`  out  `SRC_W`: index of the requester that produced `out_tdata`, registered.
- `out_tvalid`  out  1: output valid, registered.
- `out_tready`  in  1: downstream ready.

## Operation
- Transfers follow the valid/ready rule on every port: a transfer occurs when valid and ready are both high at a rising edge.
- State:
  - output slot: `out_tdata`, `out_tsrc`, `out_tvalid`.
  - round-robin pointer `ptr` (`SRC_W` bits): the highest-priority requester.
- Slot state machine:
  - EMPTY (`out_tvalid`=0) to FULL: on an input accept.
  - FULL to EMPTY: on an output transfer with no input accept in the same cycle.
  - FULL to FULL: on an output transfer plus an input accept in the same cycle (back-to-back), or while stalled.
- `slot_free = !out_tvalid || out_tready`.
- Grant is combinational:
  - Scan from `ptr` upward, modulo `NUM_IN`.
  - Pick the first i with `in_tvalid[i]`=1.
  - `in_tready[i] = slot_free && grant[i]`. All other ready bits are 0.
- On an accept from requester g:
  - load the slot with `in_tdata[g]` and `out_tsrc`=g;
  - set `out_tvalid`=1;
  - set `ptr` to g+1, wrapping to 0 when g = `NUM_IN`-1.
- With no accept, `ptr` holds. It does not advance on idle cycles.
- Grant is re-evaluated every cycle. A requester that is waiting but not granted has nothing latched. The upstream valid/ready rules require it to hold `tvalid` and `tdata` until it is accepted.
- An `in_tvalid` bit that drops without a transfer is legal. The arbiter simply skips that requester.
- When the slot is FULL and `out_tready`=0, `out_tdata`, `out_tsrc` and `out_tvalid` hold stable, and every `in_tready` bit is 0.
- Events are neither dropped nor duplicated, and per-source order is preserved.

## Timing
- Reset values:
  - `out_tvalid`=0, `out_tdata`=0, `out_tsrc`=0, `ptr`=0.
  - `in_tready` is all zero while `rst`=1, independent of other inputs.
- Latency: an input accepted at edge N is presented on `out_*` from N+1.
- Throughput: one event per cycle when `out_tready` stays high.
- Fairness: with all requesters continuously valid, each is granted exactly once in any `NUM_IN` consecutive accepts.
- Simultaneous events:
  - Output transfer and input accept on the same edge: the slot reloads and `out_tvalid` stays 1 with no bubble.
  - `rst` has priority over any transfer in the same cycle.
  - Reset mid-stream discards the slot contents and returns `ptr` to 0.
- Paths:
  - `out_tready` to `in_tready` is a combinational path.
  - There is no combinational path from `in_*` to `out_*`.

## Test plan
- Single requester, `NUM_IN`=2: requester 0 sends A1, A2, A3 while `out_tready`=1. Required: output A1, A2, A3 on consecutive cycles starting one cycle after the first accept, all with `out_tsrc`=0.
- Both requesters continuously valid: requester 0 sends 0x10..0x13 and requester 1 sends 0x20..0x23. Required output order: 0x10, 0x20, 0x11, 0x21, 0x12, 0x22, 0x13, 0x23, with `out_tsrc` alternating 0,1.
- Backpressure: slot FULL with 0x10 and `out_tready`=0 for 5 cycles while both requesters are valid. Required:
  - `out_tdata`=0x10 holds stable;
  - `in_tready` is 00 throughout;
  - after release, the next event comes from requester 1.
- Pointer wrap, `NUM_IN`=4: only requesters 3 and 1 are valid. Required grant order 1, 3, 1, 3; `ptr` goes 0→2→0→2.
- Valid drop: requester 1 asserts valid for one cycle while requester 0 is granted, then deasserts. Required: requester 1 is skipped, nothing from it is output, and no stall occurs.
- Reset mid-operation: assert `rst` while the slot is FULL and stalled. Required:
  - on the next cycle, `out_tvalid`=0 and `in_tready`=0;
  - after reset release with both requesters valid, the first grant goes to requester 0.

Source files
------------

// File: rtl/event_rr_arbiter.sv
// ---------------------------------------------------------------------------
// event_rr_arbiter
// Merges NUM_IN valid/ready event streams into one registered output slot.
// Requesters are served round-robin, starting from the one after the last
// accepted requester. Every event is tagged with the index of its source.
// Latency is one cycle and throughput is one event per cycle.
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   in_tdata    : request data, requester i at [i*DATA_W +: DATA_W]
//   in_tvalid   : per-requester valid
//   in_tready   : per-requester ready (one-hot or zero, combinational)
//   out_tdata   : arbitrated event (registered)
//   out_tsrc    : source index of out_tdata (registered)
//   out_tvalid  : output slot full (registered)
//   out_tready  : downstream ready
// ---------------------------------------------------------------------------
module event_rr_arbiter #(
   parameter int NUM_IN = 2,
   parameter int DATA_W = 96,
   parameter int SRC_W  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN*DATA_W-1:0] in_tdata,
   input  logic [NUM_IN-1:0]        in_tvalid,
   output logic [NUM_IN-1:0]        in_tready,
   output logic [DATA_W-1:0]        out_tdata,
   output logic [SRC_W-1:0]         out_tsrc,
   output logic                     out_tvalid,
   input  logic                     out_tready
);

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   slot_state_t       state_r;
   slot_state_t       state_nxt_s;
   logic [SRC_W-1:0]  ptr_r;
   logic [SRC_W-1:0]  ptr_nxt_s;
   logic [DATA_W-1:0] data_r;
   logic [SRC_W-1:0]  src_r;

   logic              slot_free_s;
   logic              grant_vld_s;
   logic              accept_s;
   logic [SRC_W-1:0]  grant_idx_s;
   logic [DATA_W-1:0] grant_data_s;
   logic [NUM_IN-1:0] ready_s;
   int                best_dist_s;
   int                dist_s;

   // Round-robin grant: the valid requester with the smallest forward
   // distance from ptr wins, which is the first valid one scanning upward.
   always_comb begin
      best_dist_s  = NUM_IN;
      dist_s       = 0;
      grant_idx_s  = '0;
      grant_data_s = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         dist_s = (i + NUM_IN - int'(ptr_r)) % NUM_IN;
         if (in_tvalid[i] && (dist_s < best_dist_s)) begin
            best_dist_s  = dist_s;
            grant_idx_s  = SRC_W'(i);
            grant_data_s = in_tdata[i*DATA_W +: DATA_W];
         end else begin
            best_dist_s  = best_dist_s;
         end
      end
      grant_vld_s = (best_dist_s < NUM_IN);
   end

   // Pointer moves to the requester just after the winner, wrapping at NUM_IN.
   always_comb begin
      if (int'(grant_idx_s) == (NUM_IN - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = grant_idx_s + SRC_W'(1);
      end
   end

   // Slot state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= SLOT_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Slot next-state: an accept always leaves the slot full; a drain without
   // an accept empties it; a stall keeps it full.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         SLOT_EMPTY: begin
            if (accept_s) begin
               state_nxt_s = SLOT_FULL;
            end else begin
               state_nxt_s = SLOT_EMPTY;
            end
         end
         SLOT_FULL: begin
            if (accept_s) begin
               state_nxt_s = SLOT_FULL;
            end else if (out_tready) begin
               state_nxt_s = SLOT_EMPTY;
            end else begin
               state_nxt_s = SLOT_FULL;
            end
         end
         default: begin
            state_nxt_s = SLOT_EMPTY;
         end
      endcase
   end

   // Slot outputs: the slot can take a new event when empty or draining.
   // Reset gates the accept so in_tready is zero throughout reset.
   always_comb begin
      slot_free_s = (state_r == SLOT_EMPTY) || out_tready;
      accept_s    = !rst && slot_free_s && grant_vld_s;
      ready_s     = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         ready_s[i] = accept_s && (grant_idx_s == SRC_W'(i));
      end
   end

   // Slot payload and round-robin pointer; both change only on an accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= '0;
         src_r  <= '0;
         ptr_r  <= '0;
      end else if (accept_s) begin
         data_r <= grant_data_s;
         src_r  <= grant_idx_s;
         ptr_r  <= ptr_nxt_s;
      end else begin
         data_r <= data_r;
         src_r  <= src_r;
         ptr_r  <= ptr_r;
      end
   end

   assign in_tready  = ready_s;
   assign out_tdata  = data_r;
   assign out_tsrc   = src_r;
   assign out_tvalid = (state_r == SLOT_FULL);

endmodule

// File: tb/tb_event_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for event_rr_arbiter.
// A two-input instance runs a table of per-cycle vectors; a four-input
// instance runs a pointer-wrap sequence and a long randomized run against a
// queue-free behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_event_rr_arbiter;

   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Two-input instance
   logic            rst2;
   logic [2*DW-1:0] in_tdata2;
   logic [1:0]      in_tvalid2;
   logic [1:0]      in_tready2;
   logic [DW-1:0]   out_tdata2;
   logic [0:0]      out_tsrc2;
   logic            out_tvalid2;
   logic            out_tready2;

   // Four-input instance
   logic            rst4;
   logic [4*DW-1:0] in_tdata4;
   logic [3:0]      in_tvalid4;
   logic [3:0]      in_tready4;
   logic [DW-1:0]   out_tdata4;
   logic [1:0]      out_tsrc4;
   logic            out_tvalid4;
   logic            out_tready4;

   event_rr_arbiter #(.NUM_IN(2), .DATA_W(DW), .SRC_W(1)) dut2 (
      .clk(clk), .rst(rst2),
      .in_tdata(in_tdata2), .in_tvalid(in_tvalid2), .in_tready(in_tready2),
      .out_tdata(out_tdata2), .out_tsrc(out_tsrc2), .out_tvalid(out_tvalid2),
      .out_tready(out_tready2)
   );

   event_rr_arbiter #(.NUM_IN(4), .DATA_W(DW), .SRC_W(2)) dut4 (
      .clk(clk), .rst(rst4),
      .in_tdata(in_tdata4), .in_tvalid(in_tvalid4), .in_tready(in_tready4),
      .out_tdata(out_tdata4), .out_tsrc(out_tsrc4), .out_tvalid(out_tvalid4),
      .out_tready(out_tready4)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  v;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        otr;
      logic [1:0]  e_rdy;
      logic        e_ov;
      logic        chkd;
      logic [15:0] e_d;
      logic        e_s;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] v, input logic [15:0] d0,
                      input logic [15:0] d1, input logic otr, input logic [1:0] e_rdy,
                      input logic e_ov, input logic chkd, input logic [15:0] e_d,
                      input logic e_s);
      vec_t x;
      x.rst = r; x.v = v; x.d0 = d0; x.d1 = d1; x.otr = otr;
      x.e_rdy = e_rdy; x.e_ov = e_ov; x.chkd = chkd; x.e_d = e_d; x.e_s = e_s;
      tbl.push_back(x);
   endtask

   // Behavioural model state for the randomized run
   int          m_ptr;
   bit          m_v;
   logic [15:0] m_d;
   int          m_s;
   int          seq[4];

   initial begin
      rst2 = 1'b1; in_tdata2 = '0; in_tvalid2 = 2'b11; out_tready2 = 1'b1;
      rst4 = 1'b1; in_tdata4 = '0; in_tvalid4 = 4'b0000; out_tready4 = 1'b1;
      repeat (2) @(posedge clk);

      // ---------------- table: rst v d0 d1 otr | rdy ov chkd data src
      add(1'b1, 2'b11, 16'h0,   16'h0,  1'b1, 2'b00, 1'b0, 1'b1, 16'h0,   1'b0); // reset state
      // single requester
      add(1'b0, 2'b01, 16'hA1,  16'h0,  1'b1, 2'b01, 1'b0, 1'b0, 16'h0,   1'b0);
      add(1'b0, 2'b01, 16'hA2,  16'h0,  1'b1, 2'b01, 1'b1, 1'b1, 16'hA1,  1'b0);
      add(1'b0, 2'b01, 16'hA3,  16'h0,  1'b1, 2'b01, 1'b1, 1'b1, 16'hA2,  1'b0);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b1, 1'b1, 16'hA3,  1'b0);
      add(1'b1, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b0, 1'b0, 16'h0,   1'b0);
      // both requesters continuously valid
      add(1'b0, 2'b11, 16'h10,  16'h20, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0,   1'b0);
      add(1'b0, 2'b11, 16'h11,  16'h20, 1'b1, 2'b10, 1'b1, 1'b1, 16'h10,  1'b0);
      add(1'b0, 2'b11, 16'h11,  16'h21, 1'b1, 2'b01, 1'b1, 1'b1, 16'h20,  1'b1);
      add(1'b0, 2'b11, 16'h12,  16'h21, 1'b1, 2'b10, 1'b1, 1'b1, 16'h11,  1'b0);
      add(1'b0, 2'b11, 16'h12,  16'h22, 1'b1, 2'b01, 1'b1, 1'b1, 16'h21,  1'b1);
      add(1'b0, 2'b11, 16'h13,  16'h22, 1'b1, 2'b10, 1'b1, 1'b1, 16'h12,  1'b0);
      add(1'b0, 2'b11, 16'h13,  16'h23, 1'b1, 2'b01, 1'b1, 1'b1, 16'h22,  1'b1);
      add(1'b0, 2'b10, 16'h0,   16'h23, 1'b1, 2'b10, 1'b1, 1'b1, 16'h13,  1'b0);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b1, 1'b1, 16'h23,  1'b1);
      // backpressure for 5 cycles
      add(1'b0, 2'b11, 16'h10,  16'h20, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0,   1'b0);
      for (int k = 0; k < 5; k++)
         add(1'b0, 2'b11, 16'h11, 16'h20, 1'b0, 2'b00, 1'b1, 1'b1, 16'h10, 1'b0);
      add(1'b0, 2'b11, 16'h11,  16'h20, 1'b1, 2'b10, 1'b1, 1'b1, 16'h10,  1'b0);
      add(1'b0, 2'b01, 16'h11,  16'h0,  1'b1, 2'b01, 1'b1, 1'b1, 16'h20,  1'b1);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b1, 1'b1, 16'h11,  1'b0);
      // valid drop on requester 1 while requester 0 wins
      add(1'b0, 2'b10, 16'h0,   16'h24, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0,   1'b0);
      add(1'b0, 2'b11, 16'h30,  16'h25, 1'b1, 2'b01, 1'b1, 1'b1, 16'h24,  1'b1);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b1, 1'b1, 16'h30,  1'b0);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b0, 1'b0, 16'h0,   1'b0);
      // reset while full and stalled
      add(1'b0, 2'b11, 16'h40,  16'h50, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0,   1'b0);
      add(1'b0, 2'b11, 16'h40,  16'h51, 1'b0, 2'b00, 1'b1, 1'b1, 16'h50,  1'b1);
      add(1'b1, 2'b11, 16'h40,  16'h51, 1'b0, 2'b00, 1'b1, 1'b1, 16'h50,  1'b1);
      add(1'b1, 2'b11, 16'h40,  16'h51, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0,   1'b0);
      add(1'b0, 2'b11, 16'h40,  16'h51, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0,   1'b0);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b1, 1'b1, 16'h40,  1'b0);
      add(1'b0, 2'b00, 16'h0,   16'h0,  1'b1, 2'b00, 1'b0, 1'b0, 16'h0,   1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst2        = tbl[i].rst;
         in_tvalid2  = tbl[i].v;
         in_tdata2   = {tbl[i].d1, tbl[i].d0};
         out_tready2 = tbl[i].otr;
         #1;
         chk($sformatf("row%0d in_tready", i), 32'(in_tready2), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d out_tvalid", i), 32'(out_tvalid2), 32'(tbl[i].e_ov));
         if (tbl[i].chkd) begin
            chk($sformatf("row%0d out_tdata", i), 32'(out_tdata2), 32'(tbl[i].e_d));
            chk($sformatf("row%0d out_tsrc", i), 32'(out_tsrc2), 32'(tbl[i].e_s));
         end
      end

      // ---------------- pointer wrap: only requesters 1 and 3 valid
      @(negedge clk);
      rst4 = 1'b1;
      repeat (2) @(negedge clk);
      rst4 = 1'b0;
      begin
         int c1 = 0;
         int c3 = 0;
         int g;
         int prev_g = 0;
         logic [15:0] prev_d = 16'h0;
         for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            in_tvalid4  = 4'b1010;
            in_tdata4   = {16'(16'h3000 + c3), 16'h0, 16'(16'h1000 + c1), 16'h0};
            out_tready4 = 1'b1;
            #1;
            g = (k % 2 == 0) ? 1 : 3;
            chk($sformatf("wrap%0d in_tready", k), 32'(in_tready4), 32'(1) << g);
            if (k > 0) begin
               chk($sformatf("wrap%0d out_tvalid", k), 32'(out_tvalid4), 32'd1);
               chk($sformatf("wrap%0d out_tsrc", k), 32'(out_tsrc4), 32'(prev_g));
               chk($sformatf("wrap%0d out_tdata", k), 32'(out_tdata4), 32'(prev_d));
            end
            prev_g = g;
            if (g == 1) begin
               prev_d = 16'(16'h1000 + c1);
               c1++;
            end else begin
               prev_d = 16'(16'h3000 + c3);
               c3++;
            end
         end
      end

      // ---------------- randomized run against the behavioural model
      @(negedge clk);
      rst4 = 1'b1;
      in_tvalid4 = 4'b0000;
      repeat (2) @(negedge clk);
      m_ptr = 0; m_v = 1'b0; m_d = 16'h0; m_s = 0;
      for (int s = 0; s < 4; s++) seq[s] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int  g;
         bit  r;
         bit  otr;
         bit  acc;
         logic [3:0] v;
         logic [3:0] e_rdy;
         if (cyc > 0) @(negedge clk);
         r   = ($urandom_range(0, 99) == 0);
         v   = 4'($urandom_range(0, 15));
         otr = ($urandom_range(0, 3) != 0);
         rst4        = r;
         in_tvalid4  = v;
         out_tready4 = otr;
         for (int s = 0; s < 4; s++)
            in_tdata4[s*DW +: DW] = 16'((s * 4096) + (seq[s] % 4096));
         #1;
         g = -1;
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
         end
         acc   = !r && (!m_v || otr) && (g >= 0);
         e_rdy = acc ? 4'(1 << g) : 4'b0000;
         chk($sformatf("rnd%0d in_tready", cyc), 32'(in_tready4), 32'(e_rdy));
         chk($sformatf("rnd%0d out_tvalid", cyc), 32'(out_tvalid4), 32'(m_v));
         if (m_v) begin
            chk($sformatf("rnd%0d out_tdata", cyc), 32'(out_tdata4), 32'(m_d));
            chk($sformatf("rnd%0d out_tsrc", cyc), 32'(out_tsrc4), 32'(m_s));
         end
         if (r) begin
            m_v = 1'b0; m_d = 16'h0; m_s = 0; m_ptr = 0;
         end else if (acc) begin
            m_v   = 1'b1;
            m_d   = 16'((g * 4096) + (seq[g] % 4096));
            m_s   = g;
            m_ptr = (g + 1) % 4;
            seq[g]++;
         end else if (otr) begin
            m_v = 1'b0;
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
